data_cache: RTL

Direct-mapped, write-through, write-allocate data cache between the CPU data port and the block-wide data port of `Memory`. It returns hits in the request cycle and fills misses with one 4-word block read. Every store updates the cached line and writes the full merged block to memory. Hit and miss counters are kept for performance reporting.

---
 rtl/data_cache.sv | 96 +++++++++
 1 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through write-allocate data cache with hit/miss counters
// Ports:
//   clk, reset                - clock and synchronous active-high reset
//   cpu_read/cpu_write        - request strobes held until cpu_ready (both high means write)
//   cpu_address, cpu_wdata    - word address and store data
//   cpu_rdata, cpu_ready      - load data and access-complete strobe
//   d_readM/d_writeM          - memory block read/write strobes
//   d_address, d_data         - block-aligned address and 64-bit bidirectional block bus
//   hit_count, miss_count     - saturating performance counters
module data_cache #(
  parameter int LINES = 4,
  parameter int MEM_READ_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        d_readM,
  output logic        d_writeM,
  output logic [15:0] d_address,
  inout  wire  [63:0] d_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int IB = $clog2(LINES);
  localparam int TB = 14 - IB;
  localparam int CW = $clog2(MEM_READ_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state;
  logic [63:0] data_q [LINES];
  logic [TB-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [CW-1:0] cnt;
  logic fill_done;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic [5:0] sh;
  logic [63:0] line, merged;
  logic [15:0] word;
  logic hit, last;
  assign idx = cpu_address[2 +: IB];
  assign tag = cpu_address[15 -: TB];
  // offset 0 lives in the top word, so the shift is 16*(3-offset)
  assign sh = {~cpu_address[1:0], 4'b0};
  assign line = data_q[idx];
  assign word = 16'(line >> sh);
  assign merged = (line & ~(64'hFFFF << sh)) | (64'(cpu_wdata) << sh);
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign last = cnt == CW'(MEM_READ_CYCLES - 1);
  assign cpu_ready = (state == IDLE && cpu_read && !cpu_write && hit) || state == WRITE;
  assign cpu_rdata = (cpu_ready && cpu_read) ? word : '0;
  assign d_readM = state == FILL;
  assign d_writeM = state == WRITE;
  assign d_address = (d_readM || d_writeM) ? {cpu_address[15:2], 2'b00} : '0;
  assign d_data = d_writeM ? merged : 'z;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid_q <= '0;
      cnt <= '0;
      fill_done <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (cpu_ready) begin
        fill_done <= 1'b0;
        if (!fill_done && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end
      case (state)
        IDLE: if (cpu_read || cpu_write) begin
          if (!hit) begin
            state <= FILL;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end else if (cpu_write) state <= WRITE;
        end
        FILL: if (last) begin
          data_q[idx] <= d_data;
          tag_q[idx] <= tag;
          valid_q[idx] <= 1'b1;
          cnt <= '0;
          fill_done <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + CW'(1);
        WRITE: begin
          data_q[idx] <= merged;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
